output_layer_mac: RTL and testbench
===================================

OUTPUT_LAYER_MAC -- requirements
Module: output_layer_mac

Interface
REQ-001 SHALL have parameter N_IN, default 32, meaning hidden activations per inference.
REQ-002 SHALL have parameter N_OUT, default 10, meaning output neurons (logits).
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of Q8.8 data, weights and bias.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  meaning pulse that begins an inference.
REQ-007 SHALL have port in_data  input  16  meaning signed Q8.8 hidden activation.
REQ-008 SHALL have port in_valid  input  1  meaning in_data is valid this cycle.
REQ-009 SHALL have port in_ready  output  1  meaning block accepts in_data this cycle.
REQ-010 SHALL have port w_addr  output  clog2(N_IN*N_OUT)  meaning weight ROM address, value j*N_IN+i.
REQ-011 SHALL have port w_data  input  16  meaning signed Q8.8 weight, valid one cycle after w_addr.
REQ-012 SHALL have port b_addr  output  clog2(N_OUT)  meaning bias ROM address, value j.
REQ-013 SHALL have port b_data  input  16  meaning signed Q8.8 bias, valid one cycle after b_addr.
REQ-014 SHALL have port out_start  output  1  meaning one-cycle pulse arming the downstream argmax.
REQ-015 SHALL have port out_data  output  16  meaning signed Q8.8 logit.
REQ-016 SHALL have port out_valid  output  1  meaning out_data holds logit j this cycle.
REQ-017 SHALL have port done  output  1  meaning one-cycle pulse after last logit.

Function
REQ-018 SHALL implement states IDLE, LOAD, MAC, DRAIN, EMIT, FINISH.
REQ-019 IDLE: start=1 -> LOAD next cycle; in_ready=0 in IDLE.
REQ-020 LOAD: in_ready=1; each cycle with in_valid=1 writes in_data to buffer[i], i increments; after N_IN-th accept -> MAC, j=0, out_start pulses in first MAC cycle.
REQ-021 LOAD: in_valid=0 cycles stall without timeout; no data dropped or duplicated.
REQ-022 MAC: N_IN cycles issuing w_addr=j*N_IN+i, i=0..N_IN-1; b_addr=j held for whole neuron; accumulator cleared in first MAC cycle of each neuron.
REQ-023 Product w_data*buffer[i] (32-bit signed, Q16.16) SHALL be accumulated one cycle after its address was issued, into a 40-bit signed accumulator.
REQ-024 DRAIN: one cycle accumulating the final product -> EMIT.
REQ-025 EMIT: out_data = saturate16((acc + (b_data sign-extended <<< FRAC)) >>> FRAC), arithmetic shift (floor); out_valid=1 for exactly this cycle.
REQ-026 Saturation: result >32767 -> 32767 (0x7FFF); result < -32768 -> -32768 (0x8000).
REQ-027 EMIT: j<N_OUT-1 -> MAC with j+1; j=N_OUT-1 -> FINISH.
REQ-028 Each neuron SHALL take exactly N_IN+2 cycles; first out_valid N_IN+2 cycles after entering MAC; N_OUT out_valid pulses, in order j=0..N_OUT-1, spaced N_IN+2 cycles apart.
REQ-029 FINISH: done=1 for one cycle -> IDLE; done is one cycle after last out_valid.
REQ-030 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-031 start and done coinciding: done completes, start ignored (block is in FINISH).
REQ-032 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-033 reset=1 SHALL, on the next rising edge, force IDLE, i=0, j=0, accumulator=0, in_ready=0, out_start=0, out_valid=0, done=0, out_data=0, w_addr=0, b_addr=0.
REQ-034 reset mid-LOAD/MAC/EMIT SHALL abort the inference; no further out_valid or done until a new start completes.
REQ-035 Buffer contents need not be cleared by reset.

Verification (N_IN=4, N_OUT=10)
REQ-036 All weights 0x0100 (1.0), bias 0, inputs 1.0,2.0,3.0,4.0 -> ten out_valid pulses, each out_data=0x0A00, done one cycle after tenth.
REQ-037 Weight row j = (j+1)*1.0, inputs all 0.5, bias j=7 0x0100 -> out_data j = (j+1)*2.0, j=7 = 0x1100; downstream argmax reports 9.
REQ-038 All weights 0x7FFF, inputs 0x7FFF -> every out_data=0x7FFF; weights 0x8000, inputs 0x7FFF -> every out_data=0x8000.
REQ-039 Inputs delivered with in_valid toggling 1,0,1,0... -> identical outputs to REQ-036; first out_valid 6 cycles after MAC entry.
REQ-040 reset asserted during 3rd neuron MAC -> no further out_valid/done; new start afterwards produces full correct sequence of REQ-036.
REQ-041 start pulsed during MAC and in_valid during MAC -> ignored; outputs unchanged from REQ-036.

Source files
------------

// File: rtl/output_layer_mac.sv
// output_layer_mac: fully-connected output layer of a small Q8.8 network.
// Buffers N_IN hidden activations, then for each of N_OUT neurons streams
// the weight row from an external synchronous ROM, accumulates the products,
// adds the bias and emits one saturated Q8.8 logit per neuron.
module output_layer_mac #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int FRAC  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic signed [15:0]                 in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [$clog2(N_IN*N_OUT)-1:0]      w_addr,
    input  logic signed [15:0]                 w_data,
    output logic [$clog2(N_OUT)-1:0]           b_addr,
    input  logic signed [15:0]                 b_data,
    output logic                               out_start,
    output logic [15:0]                        out_data,
    output logic                               out_valid,
    output logic                               done
);

    localparam int W_AW  = $clog2(N_IN * N_OUT);
    localparam int B_AW  = $clog2(N_OUT);
    localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int J_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ACC_W = 40;

    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        EMIT,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [I_W-1:0]          idx;       // activation index (LOAD write / MAC address)
    logic [I_W-1:0]          idx_d;     // index whose weight arrives on w_data this cycle
    logic [J_W-1:0]          neuron;    // current output neuron
    logic signed [15:0]      buffer [N_IN];
    logic signed [ACC_W-1:0] acc;

    logic signed [31:0]      product;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] final_sum;
    logic signed [ACC_W-1:0] shifted;
    logic [15:0]             logit;

    // ROM addresses are pure functions of the loop counters, so they read
    // zero whenever reset has cleared the counters.
    assign w_addr = W_AW'(int'(neuron) * N_IN + int'(idx));
    assign b_addr = B_AW'(neuron);

    // Product of the weight that was addressed last cycle with its activation;
    // it is meaningful in every MAC cycle except the first of a neuron, and in DRAIN.
    assign product   = w_data * buffer[idx_d];
    assign acc_sum   = acc + ACC_W'(product);
    assign bias_ext  = ACC_W'(b_data) <<< FRAC;
    assign final_sum = acc_sum + bias_ext;
    assign shifted   = final_sum >>> FRAC;

    // Clamp the Q8.8 result to the 16-bit signed range.
    always_comb begin
        if (shifted > SAT_MAX) begin
            logit = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            logit = 16'h8000;
        end else begin
            logit = shifted[15:0];
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_start = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == I_LAST) begin
                    state_nx = MAC;
                end
            end
            MAC: begin
                // Neuron 0 with index 0 occurs only in the first MAC cycle of an inference.
                out_start = (idx == '0) && (neuron == '0);
                if (idx == I_LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                state_nx  = (neuron == J_LAST) ? FINISH : MAC;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Counters, accumulator and the held output logit.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            idx_d    <= '0;
            neuron   <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            idx_d <= idx;
            case (state)
                IDLE: begin
                    idx    <= '0;
                    neuron <= '0;
                end
                LOAD: begin
                    if (in_valid) begin
                        idx <= (idx == I_LAST) ? '0 : idx + I_W'(1);
                    end
                end
                MAC: begin
                    idx <= (idx == I_LAST) ? '0 : idx + I_W'(1);
                    // First cycle of a neuron has no product in flight yet.
                    acc <= (idx == '0) ? '0 : acc_sum;
                end
                DRAIN: begin
                    // Last product lands here; the bias word has been stable
                    // since the neuron began, so the logit is formed now and
                    // is already registered during EMIT.
                    acc      <= acc_sum;
                    out_data <= logit;
                end
                EMIT: begin
                    if (neuron != J_LAST) begin
                        neuron <= neuron + J_W'(1);
                    end
                end
                FINISH: begin
                    neuron <= '0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    // Activation buffer.
    // NOTE: the buffer is deliberately left out of reset; every entry is
    // rewritten in LOAD before MAC reads it, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            buffer[idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Self-checking bench for output_layer_mac (N_IN=4, N_OUT=10) with a
// scoreboard of expected logits and a synchronous weight/bias ROM model.
module tb_output_layer_mac;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int FRAC  = 8;
    localparam int W_AW  = $clog2(N_IN * N_OUT);
    localparam int B_AW  = $clog2(N_OUT);

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic signed [15:0]     in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [W_AW-1:0]        w_addr;
    logic signed [15:0]     w_data;
    logic [B_AW-1:0]        b_addr;
    logic signed [15:0]     b_data;
    logic                   out_start;
    logic [15:0]            out_data;
    logic                   out_valid;
    logic                   done;

    output_layer_mac #(
        .N_IN (N_IN),
        .N_OUT(N_OUT),
        .FRAC (FRAC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .out_start(out_start),
        .out_data (out_data),
        .out_valid(out_valid),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs: data valid one cycle after the address.
    logic signed [15:0] wrom [N_IN*N_OUT];
    logic signed [15:0] brom [N_OUT];
    always @(posedge clk) begin
        w_data <= wrom[w_addr];
        b_data <= brom[b_addr];
    end

    logic signed [15:0] xin [N_IN];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard and monitor state.
    logic [15:0] exp_q [$];
    logic [15:0] last_out      = '0;
    int          n_valid       = 0;
    int          last_valid_cyc = 0;
    int          accept_cyc    = 0;
    bit          first_pending = 0;
    bit          expect_done   = 0;
    bit          done_seen     = 0;

    // Reference logit: floor((sum w*x + b<<FRAC) >> FRAC), saturated to 16 bits.
    function automatic logic [15:0] model(input int j);
        longint s;
        s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += longint'(wrom[j*N_IN + i]) * longint'(xin[i]);
        end
        s += longint'(brom[j]) * 256;
        s = s >>> FRAC;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // Output monitor: compares logits in order, timing, hold and done.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check("out_valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    check($sformatf("logit%0d", n_valid), out_data, exp_q.pop_front());
                end
                if (first_pending) begin
                    check("first_latency", cyc - accept_cyc, N_IN + 2);
                    first_pending = 0;
                end else begin
                    check("valid_spacing", cyc - last_valid_cyc, N_IN + 2);
                end
                n_valid++;
                last_valid_cyc = cyc;
                last_out       = out_data;
            end else begin
                check("out_data_hold", out_data, last_out);
            end
            if (done) begin
                check("done_expected", expect_done, 1);
                if (expect_done) begin
                    check("done_after_last", cyc - last_valid_cyc, 1);
                    check("valid_count", n_valid, N_OUT);
                end
                expect_done = 0;
                done_seen   = 1;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        exp_q.delete();
        last_out      = '0;
        expect_done   = 0;
        first_pending = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_done",      done,      0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_start", out_start, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_w_addr",    w_addr,    0);
        check("rst_b_addr",    b_addr,    0);
        reset = 1'b0;
    endtask

    // One inference: start pulse, deliver N_IN activations, wait for done.
    // toggle: in_valid alternates 1,0,...; inject: pulse start/in_valid in MAC;
    // abort_at >= 0: assert reset a few cycles after that many logits.
    task automatic run_inference(input bit toggle, input bit inject, input int abort_at);
        int  k;
        int  guard;
        bit  phase;
        n_valid       = 0;
        first_pending = 1;
        expect_done   = 1;
        done_seen     = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 0;
        guard = 0;
        phase = 0;
        while (k < N_IN && guard < 100) begin
            in_valid = toggle ? !phase : 1'b1;
            phase    = !phase;
            in_data  = xin[k];
            if (in_valid && in_ready) begin
                k++;
                if (k == N_IN) accept_cyc = cyc;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("load_accepts", k, N_IN);
        check("out_start_first_mac", out_start, 1);
        if (inject) begin
            @(negedge clk);
            start    = 1'b1;
            in_valid = 1'b1;
            in_data  = 16'sh7F00;
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            in_data  = '0;
        end
        if (abort_at >= 0) begin
            guard = 0;
            while (n_valid < abort_at && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            check("abort_reach", n_valid, abort_at);
            repeat (3) @(negedge clk);
            apply_reset();
        end else begin
            guard = 0;
            while (!done_seen && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check("done_seen", done_seen, 1);
            check("scoreboard_empty", exp_q.size(), 0);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic setup_basic();
        for (int a = 0; a < N_IN*N_OUT; a++) wrom[a] = 16'sh0100;
        for (int j = 0; j < N_OUT; j++) brom[j] = '0;
        for (int i = 0; i < N_IN; i++) xin[i] = 16'((i + 1) * 256);
    endtask

    task automatic push_const(input logic [15:0] v);
        for (int j = 0; j < N_OUT; j++) exp_q.push_back(v);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        setup_basic();
        repeat (2) @(negedge clk);
        apply_reset();

        // Uniform unit weights, inputs 1..4: every logit 10.0.
        setup_basic();
        push_const(16'h0A00);
        run_inference(0, 0, -1);

        // Same data with gapped in_valid.
        push_const(16'h0A00);
        run_inference(1, 0, -1);

        // Row j weight (j+1), inputs 0.5, one bias on neuron 7.
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) wrom[j*N_IN + i] = 16'((j + 1) * 256);
        for (int j = 0; j < N_OUT; j++) brom[j] = '0;
        brom[7] = 16'sh0100;
        for (int i = 0; i < N_IN; i++) xin[i] = 16'sh0080;
        for (int j = 0; j < N_OUT; j++)
            exp_q.push_back(16'((j + 1) * 512 + ((j == 7) ? 256 : 0)));
        run_inference(0, 0, -1);

        // Positive and negative saturation.
        for (int a = 0; a < N_IN*N_OUT; a++) wrom[a] = 16'sh7FFF;
        for (int j = 0; j < N_OUT; j++) brom[j] = '0;
        for (int i = 0; i < N_IN; i++) xin[i] = 16'sh7FFF;
        push_const(16'h7FFF);
        run_inference(0, 0, -1);
        for (int a = 0; a < N_IN*N_OUT; a++) wrom[a] = 16'sh8000;
        push_const(16'h8000);
        run_inference(0, 0, -1);

        // Reset during the third neuron, silence, then a clean rerun.
        setup_basic();
        push_const(16'h0A00);
        run_inference(0, 0, 2);
        repeat (40) @(negedge clk);
        push_const(16'h0A00);
        run_inference(0, 0, -1);

        // start and in_valid pulsed during MAC must be ignored.
        push_const(16'h0A00);
        run_inference(0, 1, -1);

        // Random data, including negative biases (floor rounding), vs model.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < N_IN*N_OUT; a++) wrom[a] = 16'($urandom_range(0, 65535));
            for (int j = 0; j < N_OUT; j++) brom[j] = 16'($urandom_range(0, 65535));
            for (int i = 0; i < N_IN; i++) xin[i] = 16'($urandom_range(0, 65535) >> (r * 4));
            for (int j = 0; j < N_OUT; j++) exp_q.push_back(model(j));
            run_inference(r == 1, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
